// File: rtl/adder_axi_pkg.sv
// Shared definitions for the AXI adder master: FSM states, the register map
// of the remote adder peripheral and the single-bit response encoding.
package adder_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_RD,
        S_DONE
    } state_t;

    localparam int OFS_A   = 0;
    localparam int OFS_B   = 4;
    localparam int OFS_SUM = 8;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/adder_axi_wr_chan.sv
// One AXI write (AW + W + B) for as long as start is held; AW and W complete
// independently and bready opens only once both have been accepted.
module adder_axi_wr_chan
    import adder_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    logic aw_done;
    logic w_done;

    // Flags clear on completion and whenever start drops, so an aborted
    // transfer never leaks state into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (!start || done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
        end
    end

    always_comb begin
        awvalid = start && !aw_done;
        wvalid  = start && !w_done;
        bready  = start && aw_done && w_done;
        done    = bready && bvalid;
        err     = done && (bresp != RESP_OK);
        awaddr  = start ? addr : '0;
        wdata   = start ? data : '0;
        wstrb   = start ? '1 : '0;
    end

endmodule

// File: rtl/adder_axi_master.sv
// Offloads an addition to a memory-mapped adder: writes A and B, reads the sum.
// Optional watchdog on slave stalls is enabled by defining ADDER_MASTER_TIMEOUT_EN.
module adder_axi_master
    import adder_axi_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 8,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_err,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic                    m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic                    m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_A   = ADDR_WIDTH'(BASE_ADDR + OFS_A);
    localparam logic [ADDR_WIDTH-1:0] ADDR_B   = ADDR_WIDTH'(BASE_ADDR + OFS_B);
    localparam logic [ADDR_WIDTH-1:0] ADDR_SUM = ADDR_WIDTH'(BASE_ADDR + OFS_SUM);

    state_t                  state_q;
    state_t                  state_d;
    logic                    run_q;
    logic                    ar_done_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   op_a_q;
    logic [DATA_WIDTH-1:0]   op_b_q;
    logic [DATA_WIDTH-1:0]   res_data_q;

    logic                    wr_start;
    logic                    wr_done;
    logic                    wr_err;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    cmd_fire;
    logic                    r_fire;
    logic                    res_fire;
    logic                    timeout;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign r_fire   = m1_axi_rvalid && m1_axi_rready;
    assign res_fire = res_valid && res_ready;
    assign res_data = res_data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) state_q <= S_IDLE;
        else                 state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cmd_fire) state_d = S_WR_A;
            S_WR_A: if (wr_done)  state_d = S_WR_B;
            S_WR_B: if (wr_done)  state_d = S_RD;
            S_RD:   if (r_fire)   state_d = S_DONE;
            S_DONE: if (res_ready) state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_DONE;
    end

    always_comb begin
        cmd_ready      = 1'b0;
        res_valid      = 1'b0;
        res_err        = 1'b0;
        m1_axi_arvalid = 1'b0;
        m1_axi_rready  = 1'b0;
        m1_axi_araddr  = '0;
        wr_start       = 1'b0;
        wr_addr        = ADDR_A;
        wr_data        = op_a_q;
        unique case (state_q)
            S_IDLE: cmd_ready = run_q;
            S_WR_A: wr_start = 1'b1;
            S_WR_B: begin
                wr_start = 1'b1;
                wr_addr  = ADDR_B;
                wr_data  = op_b_q;
            end
            S_RD: begin
                m1_axi_arvalid = !ar_done_q;
                m1_axi_rready  = ar_done_q;
                m1_axi_araddr  = ADDR_SUM;
            end
            S_DONE: begin
                res_valid = 1'b1;
                res_err   = err_q;
            end
            default: ;
        endcase
    end

    // run_q keeps cmd_ready low while reset is asserted even though the
    // state register already sits in IDLE.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            run_q      <= 1'b0;
            ar_done_q  <= 1'b0;
            err_q      <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_data_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (cmd_fire) begin
                op_a_q <= cmd_a;
                op_b_q <= cmd_b;
            end
            if (state_q != S_RD)
                ar_done_q <= 1'b0;
            else if (m1_axi_arvalid && m1_axi_arready)
                ar_done_q <= 1'b1;
            if (wr_err) err_q <= 1'b1;
            if (r_fire) begin
                res_data_q <= m1_axi_rdata;
                if (m1_axi_rresp == RESP_ERR) err_q <= 1'b1;
            end
            if (timeout) begin
                err_q      <= 1'b1;
                res_data_q <= '0;
            end
            if (res_fire) err_q <= 1'b0;
        end
    end

    adder_axi_wr_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_chan (
        .clk     (m1_axi_aclk),
        .rst_n   (m1_axi_aresetn),
        .start   (wr_start),
        .addr    (wr_addr),
        .data    (wr_data),
        .done    (wr_done),
        .err     (wr_err),
        .awaddr  (m1_axi_awaddr),
        .awvalid (m1_axi_awvalid),
        .awready (m1_axi_awready),
        .wdata   (m1_axi_wdata),
        .wstrb   (m1_axi_wstrb),
        .wvalid  (m1_axi_wvalid),
        .wready  (m1_axi_wready),
        .bresp   (m1_axi_bresp),
        .bvalid  (m1_axi_bvalid),
        .bready  (m1_axi_bready)
    );

`ifdef ADDER_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             waiting;
    logic             any_hs;

    // Any accepted beat proves the slave is alive and restarts the count.
    always_comb begin
        waiting = wr_start || (state_q == S_RD);
        any_hs  = (m1_axi_awvalid && m1_axi_awready) ||
                  (m1_axi_wvalid  && m1_axi_wready)  ||
                  (m1_axi_bvalid  && m1_axi_bready)  ||
                  (m1_axi_arvalid && m1_axi_arready) ||
                  r_fire;
        timeout = waiting && !any_hs && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn)        wait_cnt_q <= '0;
        else if (!waiting || any_hs) wait_cnt_q <= '0;
        else                        wait_cnt_q <= wait_cnt_q + 1'b1;
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_adder_axi_master.sv
// Directed bench for adder_axi_master with a reactive adder-peripheral slave;
// the timeout scenario runs only when ADDER_MASTER_TIMEOUT_EN is defined.
module tb_adder_axi_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready;

    int vectors     = 0;
    int miscompares = 0;

    adder_axi_master #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (8),
        .BASE_ADDR      (0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .m1_axi_aclk    (clk),
        .m1_axi_aresetn (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_err        (res_err),
        .m1_axi_awaddr  (awaddr),
        .m1_axi_awvalid (awvalid),
        .m1_axi_awready (awready),
        .m1_axi_wdata   (wdata),
        .m1_axi_wstrb   (wstrb),
        .m1_axi_wvalid  (wvalid),
        .m1_axi_wready  (wready),
        .m1_axi_bresp   (bresp),
        .m1_axi_bvalid  (bvalid),
        .m1_axi_bready  (bready),
        .m1_axi_araddr  (araddr),
        .m1_axi_arvalid (arvalid),
        .m1_axi_arready (arready),
        .m1_axi_rdata   (rdata),
        .m1_axi_rresp   (rresp),
        .m1_axi_rvalid  (rvalid),
        .m1_axi_rready  (rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- slave model (adder peripheral) ----------------
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_cyc;
        int          w_cyc;
    } wr_rec_t;

    wr_rec_t     wlog[$];
    logic [7:0]  rlog[$];
    logic [31:0] mem [0:255];

    int          aw_hold   = 1;
    int          w_hold    = 1;
    int          ar_hold   = 1;
    bit          rvalid_en = 1'b1;
    bit          err_en    = 1'b0;
    logic [7:0]  err_addr  = 8'h00;
    int          bready_early = 0;

    initial begin
        int          aw_cnt;
        int          w_cnt;
        int          ar_cnt;
        bit          got_aw;
        bit          got_w;
        bit          got_ar;
        logic [7:0]  aw_addr_cap;
        logic [31:0] w_data_cap;
        logic [3:0]  w_strb_cap;
        int          aw_cyc_cap;
        int          w_cyc_cap;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_addr_cap = '0; w_data_cap = '0; w_strb_cap = '0;
        aw_cyc_cap = 0; w_cyc_cap = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                got_aw = 0; got_w = 0; got_ar = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rresp = 0;
                continue;
            end
            // B response uses handshakes completed at earlier edges
            if (bready && !(got_aw && got_w)) bready_early++;
            bvalid = got_aw && got_w;
            bresp  = err_en && (aw_addr_cap == err_addr);
            if (bvalid && bready) begin
                mem[aw_addr_cap] = w_data_cap;
                wlog.push_back('{aw_addr_cap, w_data_cap, w_strb_cap, aw_cyc_cap, w_cyc_cap});
                got_aw = 0;
                got_w  = 0;
            end
            rvalid = got_ar && rvalid_en;
            rdata  = mem[0] + mem[4];
            rresp  = 1'b0;
            if (rvalid && rready) got_ar = 0;
            if (awvalid && !got_aw) begin
                awready = (aw_cnt == aw_hold - 1);
                aw_cnt++;
                if (awready) begin
                    got_aw = 1; aw_addr_cap = awaddr; aw_cyc_cap = aw_cnt; aw_cnt = 0;
                end
            end else begin
                awready = 0; aw_cnt = 0;
            end
            if (wvalid && !got_w) begin
                wready = (w_cnt == w_hold - 1);
                w_cnt++;
                if (wready) begin
                    got_w = 1; w_data_cap = wdata; w_strb_cap = wstrb; w_cyc_cap = w_cnt; w_cnt = 0;
                end
            end else begin
                wready = 0; w_cnt = 0;
            end
            if (arvalid && !got_ar) begin
                arready = (ar_cnt == ar_hold - 1);
                ar_cnt++;
                if (arready) begin
                    got_ar = 1; rlog.push_back(araddr); ar_cnt = 0;
                end
            end else begin
                arready = 0; ar_cnt = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge with res_valid high.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] data, output logic err);
        int n;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        data = res_data;
        err  = res_err;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          lat;
        int          n;
        int          rd_before;
        logic [31:0] data;
        logic        err;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_awaddr_wdata", {awaddr, wdata, wstrb}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Basic zero-wait transaction
        run_cmd(32'h0000AABB, 32'h0000CCDD, lat, data, err);
        check("basic_latency", lat, 7);
        check("basic_res_data", data, 32'h00017798);
        check("basic_res_err", err, 0);
        check("basic_wr_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("basic_wa_addr", wlog[0].addr, 8'h00);
            check("basic_wa_data", wlog[0].data, 32'h0000AABB);
            check("basic_wa_strb", wlog[0].strb, 4'hF);
            check("basic_wb_addr", wlog[1].addr, 8'h04);
            check("basic_wb_data", wlog[1].data, 32'h0000CCDD);
        end
        check("basic_rd_count", rlog.size(), 1);
        if (rlog.size() == 1) check("basic_rd_addr", rlog[0], 8'h08);
        check("basic_bready_order", bready_early, 0);

        // Slow AW channel, wrap-around sum
        @(negedge clk);
        wlog.delete();
        aw_hold = 3;
        run_cmd(32'h00000001, 32'hFFFFFFFF, lat, data, err);
        aw_hold = 1;
        check("slowaw_latency", lat, 11);
        check("slowaw_res_data", data, 32'h00000000);
        check("slowaw_res_err", err, 0);
        check("slowaw_wr_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("slowaw_a_awcyc", wlog[0].aw_cyc, 3);
            check("slowaw_a_wcyc", wlog[0].w_cyc, 1);
            check("slowaw_b_awcyc", wlog[1].aw_cyc, 3);
            check("slowaw_b_data", wlog[1].data, 32'hFFFFFFFF);
        end
        check("slowaw_bready_order", bready_early, 0);

        // Error response on the operand-B write
        @(negedge clk);
        rd_before = rlog.size();
        err_en = 1'b1; err_addr = 8'h04;
        run_cmd(32'h80000000, 32'h7FFFFFFF, lat, data, err);
        err_en = 1'b0;
        check("berr_res_err", err, 1);
        check("berr_res_data", data, 32'hFFFFFFFF);
        check("berr_read_issued", rlog.size(), rd_before + 1);
        @(negedge clk);
        run_cmd(32'h00000003, 32'h00000004, lat, data, err);
        check("after_err_res_err", err, 0);
        check("after_err_res_data", data, 32'h00000007);

        // Consumer back-pressure
        @(negedge clk);
        res_ready = 1'b0;
        run_cmd(32'h00001000, 32'h00000234, lat, data, err);
        check("bp_latency", lat, 7);
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", res_valid, 1);
            check("bp_res_data", res_data, 32'h00001234);
            check("bp_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_res_valid", res_valid, 0);
        check("bp_release_cmd_ready", cmd_ready, 1);

        // Reset while the read address is outstanding
        cmd_a = 32'h00000005; cmd_b = 32'h00000007; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!arvalid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_arvalid_seen", arvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_outputs", {cmd_ready, awvalid, wvalid, bready, rready, res_valid, res_err}, 0);
        check("mid_rst_res_data", res_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_res_valid", res_valid, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(32'h12345678, 32'h11111111, lat, data, err);
        check("post_mid_rst_latency", lat, 7);
        check("post_mid_rst_res_data", data, 32'h23456789);
        check("post_mid_rst_res_err", err, 0);

`ifdef ADDER_MASTER_TIMEOUT_EN
        // Slave never returns read data
        @(negedge clk);
        rvalid_en = 1'b0;
        run_cmd(32'h00000011, 32'h00000022, lat, data, err);
        check("tmo_res_valid", res_valid, 1);
        check("tmo_res_err", err, 1);
        check("tmo_res_data", data, 0);
        check("tmo_rready", rready, 0);
        check("tmo_arvalid", arvalid, 0);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
